// File: rtl/sr_flop_bank_if.sv
// Signal bundle for sr_flop_bank: per-channel set/reset/clear requests and the
// registered state, conflict and change outputs.
interface sr_flop_bank_if #(
    parameter int unsigned WIDTH = 8
);
    logic [WIDTH-1:0] set;
    logic [WIDTH-1:0] reset;
    logic [WIDTH-1:0] conflict_clr;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] q_not;
    logic [WIDTH-1:0] conflict;
    logic [WIDTH-1:0] changed;

    modport master (
        output set, reset, conflict_clr,
        input  q, q_not, conflict, changed
    );

    modport slave (
        input  set, reset, conflict_clr,
        output q, q_not, conflict, changed
    );
endinterface

// File: rtl/sr_flop_bank.sv
// Bank of WIDTH independent clocked SR channels with per-channel run-length input
// qualification, selectable S=R=1 resolution, sticky conflict flag and change pulse.
module sr_flop_bank #(
    parameter int unsigned      WIDTH     = 8,
    parameter int unsigned      FILTER    = 1,
    parameter int unsigned      MODE      = 0,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input logic           clk,
    input logic           rst,
    sr_flop_bank_if.slave bus
);
    localparam int unsigned     CntW      = (FILTER < 2) ? 1 : $clog2(FILTER + 1);
    localparam logic [CntW-1:0] FilterCnt = CntW'(FILTER);

    logic [WIDTH-1:0][CntW-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0][1:0]      prev_q, prev_d;
    logic [WIDTH-1:0]           q_q, q_d;
    logic [WIDTH-1:0]           q_not_q;
    logic [WIDTH-1:0]           conflict_q, conflict_d;
    logic [WIDTH-1:0]           changed_q, changed_d;

    logic [WIDTH-1:0][1:0]      code;
    logic [WIDTH-1:0][CntW-1:0] run;
    logic [WIDTH-1:0]           qual;

    always_comb begin
        cnt_d      = cnt_q;
        prev_d     = prev_q;
        q_d        = q_q;
        conflict_d = conflict_q & ~bus.conflict_clr;
        code       = '0;
        run        = '0;
        qual       = '0;
        for (int i = 0; i < WIDTH; i++) begin
            code[i] = {bus.set[i], bus.reset[i]};
            // Run length restarts on any code change; saturates at FILTER, never wraps.
            if ((cnt_q[i] != '0) && (code[i] == prev_q[i])) begin
                run[i] = (cnt_q[i] >= FilterCnt) ? FilterCnt : cnt_q[i] + 1'b1;
            end else begin
                run[i] = CntW'(1);
            end
            qual[i]   = (run[i] >= FilterCnt);
            cnt_d[i]  = run[i];
            prev_d[i] = code[i];
            if (qual[i]) begin
                case (code[i])
                    2'b10: q_d[i] = 1'b1;
                    2'b01: q_d[i] = 1'b0;
                    2'b11: begin
                        // Set wins over a simultaneous conflict_clr.
                        conflict_d[i] = 1'b1;
                        case (MODE)
                            1:       q_d[i] = 1'b1;
                            2:       q_d[i] = 1'b0;
                            3:       q_d[i] = ~q_q[i];
                            default: q_d[i] = q_q[i];
                        endcase
                    end
                    default: q_d[i] = q_q[i];
                endcase
            end
        end
        changed_d = q_d ^ q_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q      <= '0;
            prev_q     <= '0;
            q_q        <= RESET_VAL;
            q_not_q    <= ~RESET_VAL;
            conflict_q <= '0;
            changed_q  <= '0;
        end else begin
            cnt_q      <= cnt_d;
            prev_q     <= prev_d;
            q_q        <= q_d;
            q_not_q    <= ~q_d;
            conflict_q <= conflict_d;
            changed_q  <= changed_d;
        end
    end

    assign bus.q        = q_q;
    assign bus.q_not    = q_not_q;
    assign bus.conflict = conflict_q;
    assign bus.changed  = changed_q;
endmodule

// File: tb/tb_sr_flop_bank.sv
// Directed self-checking bench for sr_flop_bank: six instances share one stimulus
// and cover reset, plain SR, glitch filtering, all conflict modes and mid-run reset.
module tb_sr_flop_bank;
    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] set_s, reset_s, clr_s;
    int         n_run  = 0;
    int         n_fail = 0;

    always #5 clk = ~clk;

    sr_flop_bank_if #(.WIDTH(4)) if_m0 ();
    sr_flop_bank_if #(.WIDTH(4)) if_m1 ();
    sr_flop_bank_if #(.WIDTH(4)) if_m2 ();
    sr_flop_bank_if #(.WIDTH(4)) if_m3 ();
    sr_flop_bank_if #(.WIDTH(4)) if_f3 ();
    sr_flop_bank_if #(.WIDTH(4)) if_f4 ();

    assign if_m0.set = set_s;  assign if_m0.reset = reset_s;  assign if_m0.conflict_clr = clr_s;
    assign if_m1.set = set_s;  assign if_m1.reset = reset_s;  assign if_m1.conflict_clr = clr_s;
    assign if_m2.set = set_s;  assign if_m2.reset = reset_s;  assign if_m2.conflict_clr = clr_s;
    assign if_m3.set = set_s;  assign if_m3.reset = reset_s;  assign if_m3.conflict_clr = clr_s;
    assign if_f3.set = set_s;  assign if_f3.reset = reset_s;  assign if_f3.conflict_clr = clr_s;
    assign if_f4.set = set_s;  assign if_f4.reset = reset_s;  assign if_f4.conflict_clr = clr_s;

    sr_flop_bank #(.WIDTH(4), .FILTER(1), .MODE(0), .RESET_VAL(4'b1010)) u_m0 (
        .clk(clk), .rst(rst), .bus(if_m0)
    );
    sr_flop_bank #(.WIDTH(4), .FILTER(1), .MODE(1), .RESET_VAL(4'b1010)) u_m1 (
        .clk(clk), .rst(rst), .bus(if_m1)
    );
    sr_flop_bank #(.WIDTH(4), .FILTER(1), .MODE(2), .RESET_VAL(4'b1010)) u_m2 (
        .clk(clk), .rst(rst), .bus(if_m2)
    );
    sr_flop_bank #(.WIDTH(4), .FILTER(1), .MODE(3), .RESET_VAL(4'b1010)) u_m3 (
        .clk(clk), .rst(rst), .bus(if_m3)
    );
    sr_flop_bank #(.WIDTH(4), .FILTER(3), .MODE(0), .RESET_VAL(4'b0000)) u_f3 (
        .clk(clk), .rst(rst), .bus(if_f3)
    );
    sr_flop_bank #(.WIDTH(4), .FILTER(4), .MODE(0), .RESET_VAL(4'b1010)) u_f4 (
        .clk(clk), .rst(rst), .bus(if_f4)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; set_s = '0; reset_s = '0; clr_s = '0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; set_s = 4'hF; reset_s = '0; clr_s = '0;
        for (int e = 0; e < 2; e++) begin
            tick();
            n_run++;
            if (if_m0.q !== 4'b1010) begin
                n_fail++; $display("FAIL reset_q edge%0d: got %b want 1010", e, if_m0.q);
            end
            n_run++;
            if (if_m0.q_not !== 4'b0101) begin
                n_fail++; $display("FAIL reset_q_not edge%0d: got %b want 0101", e, if_m0.q_not);
            end
            n_run++;
            if (if_m0.conflict !== 4'b0000 || if_m0.changed !== 4'b0000) begin
                n_fail++;
                $display("FAIL reset_flags edge%0d: got conflict=%b changed=%b want 0000/0000",
                         e, if_m0.conflict, if_m0.changed);
            end
            n_run++;
            if (if_f3.q !== 4'b0000) begin
                n_fail++; $display("FAIL reset_q_f3 edge%0d: got %b want 0000", e, if_f3.q);
            end
        end
        rst = 1'b0; set_s = '0;
    endtask

    task automatic test_basic();
        set_s = 4'b0001;
        tick();
        n_run++;
        if (if_m0.q !== 4'b1011 || if_m0.changed !== 4'b0001) begin
            n_fail++; $display("FAIL basic_set: got q=%b changed=%b want 1011/0001",
                               if_m0.q, if_m0.changed);
        end
        set_s = '0;
        tick();
        n_run++;
        if (if_m0.q !== 4'b1011 || if_m0.changed !== 4'b0000) begin
            n_fail++; $display("FAIL basic_hold: got q=%b changed=%b want 1011/0000",
                               if_m0.q, if_m0.changed);
        end
        reset_s = 4'b0001;
        tick();
        n_run++;
        if (if_m0.q !== 4'b1010 || if_m0.changed !== 4'b0001) begin
            n_fail++; $display("FAIL basic_reset: got q=%b changed=%b want 1010/0001",
                               if_m0.q, if_m0.changed);
        end
        n_run++;
        if (if_m0.q_not !== 4'b0101) begin
            n_fail++; $display("FAIL basic_q_not: got %b want 0101", if_m0.q_not);
        end
        reset_s = '0;
        tick();
        n_run++;
        if (if_m0.changed !== 4'b0000) begin
            n_fail++; $display("FAIL basic_pulse_end: got changed=%b want 0000", if_m0.changed);
        end
    endtask

    task automatic test_glitch_filter();
        do_reset();
        // Two-cycle pulse followed by 00: must never qualify.
        for (int e = 0; e < 3; e++) begin
            set_s = (e < 2) ? 4'b0010 : 4'b0000;
            tick();
            n_run++;
            if (if_f3.q !== 4'b0000) begin
                n_fail++; $display("FAIL glitch_short edge%0d: got %b want 0000", e, if_f3.q);
            end
        end
        set_s = 4'b0010;
        for (int e = 0; e < 5; e++) begin
            logic [3:0] exp_q, exp_ch;
            tick();
            exp_q  = (e >= 2) ? 4'b0010 : 4'b0000;
            exp_ch = (e == 2) ? 4'b0010 : 4'b0000;
            n_run++;
            if (if_f3.q !== exp_q || if_f3.changed !== exp_ch) begin
                n_fail++;
                $display("FAIL glitch_qualify edge%0d: got q=%b changed=%b want %b/%b",
                         e, if_f3.q, if_f3.changed, exp_q, exp_ch);
            end
        end
        set_s = '0;
    endtask

    task automatic test_conflict_modes();
        do_reset();
        set_s = 4'b0001; reset_s = 4'b0001;
        for (int e = 0; e < 4; e++) begin
            logic exp3;
            tick();
            exp3 = (e % 2 == 0);
            n_run++;
            if (if_m0.q[0] !== 1'b0 || if_m1.q[0] !== 1'b1 || if_m2.q[0] !== 1'b0
                || if_m3.q[0] !== exp3) begin
                n_fail++;
                $display("FAIL conflict_q edge%0d: got m0..m3=%b%b%b%b want 01 0 %b",
                         e, if_m0.q[0], if_m1.q[0], if_m2.q[0], if_m3.q[0], exp3);
            end
            n_run++;
            if ({if_m0.conflict[0], if_m1.conflict[0], if_m2.conflict[0],
                 if_m3.conflict[0]} !== 4'b1111) begin
                n_fail++;
                $display("FAIL conflict_flag edge%0d: got %b%b%b%b want 1111", e,
                         if_m0.conflict[0], if_m1.conflict[0], if_m2.conflict[0],
                         if_m3.conflict[0]);
            end
        end
        set_s = '0; reset_s = '0;
        tick();
        n_run++;
        if ({if_m0.conflict[0], if_m1.conflict[0], if_m2.conflict[0],
             if_m3.conflict[0]} !== 4'b1111) begin
            n_fail++;
            $display("FAIL conflict_sticky: got %b%b%b%b want 1111", if_m0.conflict[0],
                     if_m1.conflict[0], if_m2.conflict[0], if_m3.conflict[0]);
        end
        n_run++;
        if (if_m1.q[0] !== 1'b1 || if_m3.q[0] !== 1'b0) begin
            n_fail++; $display("FAIL conflict_release_hold: got m1=%b m3=%b want 1/0",
                               if_m1.q[0], if_m3.q[0]);
        end
    endtask

    task automatic test_conflict_clear();
        clr_s = 4'b0001;
        tick();
        n_run++;
        if (if_m0.conflict[0] !== 1'b0) begin
            n_fail++; $display("FAIL conflict_clr: got %b want 0", if_m0.conflict[0]);
        end
        clr_s = '0; set_s = 4'b0001; reset_s = 4'b0001;
        tick();
        n_run++;
        if (if_m0.conflict[0] !== 1'b1) begin
            n_fail++; $display("FAIL conflict_reassert: got %b want 1", if_m0.conflict[0]);
        end
        clr_s = 4'b0001;
        tick();
        n_run++;
        if (if_m0.conflict[0] !== 1'b1) begin
            n_fail++; $display("FAIL conflict_set_wins: got %b want 1", if_m0.conflict[0]);
        end
        clr_s = '0; set_s = '0; reset_s = '0;
    endtask

    task automatic test_reset_mid_run();
        do_reset();
        set_s = 4'b0100;
        for (int e = 0; e < 3; e++) begin
            tick();
            n_run++;
            if (if_f4.q[2] !== 1'b0) begin
                n_fail++; $display("FAIL midrst_pre edge%0d: got %b want 0", e, if_f4.q[2]);
            end
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_run++;
        if (if_f4.q !== 4'b1010 || if_f4.changed !== 4'b0000) begin
            n_fail++; $display("FAIL midrst_reset: got q=%b changed=%b want 1010/0000",
                               if_f4.q, if_f4.changed);
        end
        for (int e = 0; e < 4; e++) begin
            logic exp_q2;
            tick();
            exp_q2 = (e == 3);
            n_run++;
            if (if_f4.q[2] !== exp_q2) begin
                n_fail++; $display("FAIL midrst_post edge%0d: got %b want %b",
                                   e, if_f4.q[2], exp_q2);
            end
        end
        set_s = '0;
    endtask

    initial begin
        rst = 1'b1; set_s = '0; reset_s = '0; clr_s = '0;
        test_reset();
        test_basic();
        test_glitch_filter();
        test_conflict_modes();
        test_conflict_clear();
        test_reset_mid_run();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
